// File: rtl/cut_exhaustive_signature.sv
// Exhaustive-sweep harness for a combinational (or pipelined) circuit under test.
// On start, every input vector 0..2^N_IN-1 is driven onto cut_in once, in order.
// Each response is folded into a MISR signature and into one ones-counter per output.
module cut_exhaustive_signature #(
    parameter int unsigned      N_IN    = 5,
    parameter int unsigned      N_OUT   = 19,
    parameter int unsigned      CUT_LAT = 1,
    parameter int unsigned      SIG_W   = 32,
    parameter logic [SIG_W-1:0] POLY    = SIG_W'(32'h04C11DB7),
    parameter logic [SIG_W-1:0] SEED    = SIG_W'(32'hFFFFFFFF),
    localparam int unsigned     SEL_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int unsigned     CNT_W   = N_IN + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  cut_in,
    input  logic [N_OUT-1:0] cut_out,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] sig_out,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0] rd_count
);

    typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

    localparam int unsigned     N_CHUNK   = (N_OUT + SIG_W - 1) / SIG_W;
    localparam logic [N_IN-1:0] LAST_VEC  = '1;
    localparam logic [SEL_W:0]  N_OUT_SEL = (SEL_W + 1)'(N_OUT);

    state_e                     state_q;
    // Bit j set means the vector issued j+1 edges ago still awaits its sample.
    logic [CUT_LAT-1:0]         vld_q;
    logic [CUT_LAT-1:0]         vld_shift;
    logic [CNT_W-1:0]           cnt_q [N_OUT];
    logic [N_CHUNK*SIG_W-1:0]   padded;
    logic [SIG_W-1:0]           fold;
    logic [SIG_W-1:0]           sig_next;
    logic                       running;
    logic                       start_sweep;
    logic                       sample_en;

    // Control decode shared by the FSM and the datapath.
    always_comb begin
        running     = (state_q == StSweep) || (state_q == StDrain);
        start_sweep = start && ((state_q == StIdle) || (state_q == StDone));
        // abort wins over a sample that would land on the same edge
        sample_en   = running && !abort && vld_q[CUT_LAT-1];
    end

    // Valid chain advanced by one position with nothing entering.
    always_comb begin
        vld_shift = '0;
        for (int i = 1; i < CUT_LAT; i++) begin
            vld_shift[i] = vld_q[i-1];
        end
    end

    // Fold the response into SIG_W-bit chunks and compute the next MISR value.
    always_comb begin
        padded             = '0;
        padded[N_OUT-1:0]  = cut_out;
        fold               = '0;
        for (int c = 0; c < N_CHUNK; c++) begin
            fold = fold ^ padded[c*SIG_W +: SIG_W];
        end
        sig_next = {sig_out[SIG_W-2:0], 1'b0} ^ (sig_out[SIG_W-1] ? POLY : '0) ^ fold;
    end

    // Sweep FSM: vector counter, valid chain and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cut_in  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            vld_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= StSweep;
                        cut_in  <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        vld_q   <= CUT_LAT'(1);
                    end
                end
                StSweep: begin
                    if (abort) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        vld_q   <= '0;
                    end else if (cut_in == LAST_VEC) begin
                        // last vector already issued; hold it while the pipe drains
                        state_q <= StDrain;
                        vld_q   <= vld_shift;
                    end else begin
                        cut_in  <= cut_in + N_IN'(1);
                        vld_q   <= vld_shift | CUT_LAT'(1);
                    end
                end
                StDrain: begin
                    if (abort) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        vld_q   <= '0;
                    end else if (vld_q == '0) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        vld_q   <= vld_shift;
                    end
                end
            endcase
        end
    end

    // Signature and ones counters: seeded on start, updated once per valid sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_out <= '0;
            for (int i = 0; i < N_OUT; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (start_sweep) begin
            sig_out <= SEED;
            for (int i = 0; i < N_OUT; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (sample_en) begin
            sig_out <= sig_next;
            for (int i = 0; i < N_OUT; i++) begin
                cnt_q[i] <= cnt_q[i] + CNT_W'(cut_out[i]);
            end
        end
    end

    // Count readback; out-of-range selects read as zero.
    always_comb begin
        rd_count = '0;
        if ({1'b0, rd_sel} < N_OUT_SEL) begin
            rd_count = cnt_q[rd_sel];
        end
    end

endmodule

// File: tb/tb_cut_exhaustive_signature.sv
// Randomised bench for cut_exhaustive_signature: two instances (CUT_LAT=1 with 19 outputs,
// CUT_LAT=3 with 40 outputs so the chunk fold is exercised) checked every cycle against
// a vector-level reference model, plus literal timing/count expectations.
module tb_cut_exhaustive_signature;

    localparam int          NV   = 32;
    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  cut_in1, cut_in3;
    logic [18:0] cut_out1;
    logic [39:0] resp1, resp3, pipe1, cut_out3;
    logic        busy1, done1, busy3, done3;
    logic [31:0] sig1, sig3;
    logic [4:0]  rd_sel1;
    logic [5:0]  rd_sel3;
    logic [5:0]  rd_count1, rd_count3;
    logic        rd_hold = 1'b0;
    logic [5:0]  rd_val = '0;

    int          mode = 0;
    logic [39:0] tbl [NV];

    int checks = 0;
    int errors = 0;

    // reference model state, index 0 = LAT1 instance, 1 = LAT3 instance
    bit          m_run   [2];
    bit          m_done  [2];
    bit          m_fresh [2];
    int          m_t     [2];
    logic [31:0] m_sig   [2];
    int          m_cut   [2];
    int          m_cnt   [2][40];

    always #5 clk = ~clk;

    // CUT models: 0 identity, 1 constant zero, 2 random lookup table
    assign resp1    = (mode == 0) ? 40'(cut_in1) : (mode == 1) ? 40'h0 : tbl[cut_in1];
    assign resp3    = (mode == 0) ? 40'(cut_in3) : (mode == 1) ? 40'h0 : tbl[cut_in3];
    assign cut_out1 = resp1[18:0];

    // two register stages give the LAT3 instance a three-edge CUT latency
    always @(posedge clk) begin
        pipe1    <= resp3;
        cut_out3 <= pipe1;
    end

    cut_exhaustive_signature #(
        .N_IN(5), .N_OUT(19), .CUT_LAT(1), .SIG_W(32), .POLY(POLY), .SEED(SEED)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cut_in(cut_in1), .cut_out(cut_out1), .busy(busy1), .done(done1),
        .sig_out(sig1), .rd_sel(rd_sel1), .rd_count(rd_count1)
    );

    cut_exhaustive_signature #(
        .N_IN(5), .N_OUT(40), .CUT_LAT(3), .SIG_W(32), .POLY(POLY), .SEED(SEED)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cut_in(cut_in3), .cut_out(cut_out3), .busy(busy3), .done(done3),
        .sig_out(sig3), .rd_sel(rd_sel3), .rd_count(rd_count3)
    );

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int nout_of(input int i);
        return (i == 0) ? 19 : 40;
    endfunction

    function automatic logic [39:0] cut_fn(input int md, input int v);
        if (md == 0) return 40'(v);
        if (md == 1) return 40'h0;
        return tbl[v];
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] f);
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
    endfunction

    function automatic logic [31:0] fold32(input logic [39:0] r, input int n);
        logic [31:0] f = '0;
        for (int b = 0; b < n; b++) f[b % 32] ^= r[b];
        return f;
    endfunction

    task automatic chk(input string nm, input int i, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d @%0t got %0h want %0h", nm, i, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_done[i] = 0; m_fresh[i] = 1; m_t[i] = 0;
            m_sig[i] = '0; m_cut[i] = 0;
            for (int b = 0; b < 40; b++) m_cnt[i][b] = 0;
        end
    endtask

    task automatic model_step(input int i);
        int          k;
        logic [39:0] r;
        if (!m_run[i]) begin
            if (start) begin
                m_run[i] = 1; m_done[i] = 0; m_fresh[i] = 0; m_t[i] = 0;
                m_sig[i] = SEED; m_cut[i] = 0;
                for (int b = 0; b < 40; b++) m_cnt[i][b] = 0;
            end
        end else if (abort) begin
            m_run[i]  = 0;
            m_done[i] = 0;
        end else begin
            m_t[i]++;
            k = m_t[i] - lat_of(i);
            if (k >= 0 && k < NV) begin
                r        = cut_fn(mode, k);
                m_sig[i] = misr_step(m_sig[i], fold32(r, nout_of(i)));
                for (int b = 0; b < nout_of(i); b++) m_cnt[i][b] += int'(r[b]);
            end
            m_cut[i] = (m_t[i] < NV) ? m_t[i] : NV - 1;
            if (m_t[i] == NV + lat_of(i)) begin
                m_run[i]  = 0;
                m_done[i] = 1;
            end
        end
    endtask

    task automatic compare_inst(input int i, input logic b, input logic d,
                                input logic [4:0] ci, input logic [31:0] s,
                                input logic [5:0] rc, input logic [5:0] sel);
        int exp_rc;
        exp_rc = (int'(sel) < nout_of(i)) ? m_cnt[i][sel] : 0;
        chk("busy", i, 64'(b), 64'(m_run[i]));
        chk("done", i, 64'(d), 64'(m_done[i]));
        chk("sig", i, 64'(s), 64'(m_sig[i]));
        chk("rd_count", i, 64'(rc), 64'(exp_rc));
        if (m_run[i] || m_fresh[i]) chk("cut_in", i, 64'(ci), 64'(m_cut[i]));
    endtask

    // model advances on every clock edge or asynchronous reset
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                model_step(0);
                model_step(1);
            end
        end
    end

    // single compare point, half a cycle after each active edge
    initial begin
        forever begin
            @(negedge clk);
            compare_inst(0, busy1, done1, cut_in1, sig1, rd_count1, {1'b0, rd_sel1});
            compare_inst(1, busy3, done3, cut_in3, sig3, rd_count3, rd_sel3);
        end
    end

    // readback select: random unless the main sequence pins it
    initial begin
        rd_sel1 = '0;
        rd_sel3 = '0;
        forever begin
            @(posedge clk);
            #2;
            rd_sel3 = rd_hold ? rd_val : 6'($urandom_range(0, 47));
            rd_sel1 = rd_hold ? rd_val[4:0] : 5'($urandom);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // returns the edge index (start edge = 0) at which done was first seen
    task automatic wait_done(output int e1, output int e3);
        int e = 0;
        e1 = -1;
        e3 = -1;
        for (int n = 0; n < 120; n++) begin
            @(negedge clk);
            if (done1 && e1 < 0) e1 = e;
            if (done3 && e3 < 0) e3 = e;
            if (e1 >= 0 && e3 >= 0) break;
            step();
            e++;
        end
        if (e1 < 0 || e3 < 0) chk("done_timeout", 0, 64'(e1 >= 0 && e3 >= 0), 64'd1);
        step();
    endtask

    task automatic check_counts(input int ones_bits, input int ones_val);
        rd_hold = 1'b1;
        for (int s = 0; s < 20; s++) begin
            rd_val = 6'(s);
            @(posedge clk);
            #3;
            @(negedge clk);
            chk("lit_cnt", 0, 64'(rd_count1), 64'((s < ones_bits) ? ones_val : 0));
            chk("lit_cnt", 1, 64'(rd_count3), 64'((s < ones_bits) ? ones_val : 0));
        end
        rd_hold = 1'b0;
        step();
    endtask

    initial begin
        int e1, e3;
        for (int v = 0; v < NV; v++) tbl[v] = {8'($urandom), 32'($urandom)};

        // pin the model's arithmetic with hand-computed values
        chk("lit_misr_ff", 0, 64'(misr_step(32'hFFFFFFFF, 32'h0)), 64'h FB3EE249);
        chk("lit_misr_msb", 0, 64'(misr_step(32'h80000000, 32'h0)), 64'h04C11DB7);
        chk("lit_misr_in", 0, 64'(misr_step(32'h0, 32'h5)), 64'h5);
        chk("lit_fold_cancel", 0, 64'(fold32(40'h01_0000_0001, 40)), 64'h0);
        chk("lit_fold_hi", 0, 64'(fold32(40'h80_0000_0000, 40)), 64'h80);

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("lit_rst_sig", 0, 64'(sig1), 64'h0);
        chk("lit_rst_cut", 0, 64'(cut_in1), 64'h0);
        chk("lit_rst_busy", 1, 64'(busy3), 64'h0);
        step();
        rst_n = 1'b1;
        step();

        // identity CUT: done at edge 33 / 35, each input bit is one in half the vectors
        mode = 0;
        pulse_start();
        wait_done(e1, e3);
        chk("lit_done_edge", 0, 64'(e1), 64'd33);
        chk("lit_done_edge", 1, 64'(e3), 64'd35);
        check_counts(5, 16);

        // constant-zero CUT: every count zero
        mode = 1;
        pulse_start();
        wait_done(e1, e3);
        check_counts(0, 0);

        // abort at edge 10, then a clean restart
        mode = 0;
        pulse_start();
        repeat (9) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        chk("lit_abort_busy", 0, 64'(busy1), 64'h0);
        chk("lit_abort_done", 1, 64'(done3), 64'h0);
        step();
        pulse_start();
        wait_done(e1, e3);
        chk("lit_done_edge", 0, 64'(e1), 64'd33);

        // start while busy is ignored; start in DONE reseeds
        mode = 2;
        pulse_start();
        repeat (5) step();
        pulse_start();
        wait_done(e1, e3);
        pulse_start();
        @(negedge clk);
        chk("lit_reseed", 0, 64'(sig1), 64'(SEED));
        chk("lit_restart_cut", 0, 64'(cut_in1), 64'h0);
        step();
        wait_done(e1, e3);

        // asynchronous reset mid-sweep
        mode = 0;
        pulse_start();
        repeat (19) step();
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("lit_arst_sig", 0, 64'(sig1), 64'h0);
        chk("lit_arst_busy", 1, 64'(busy3), 64'h0);
        step();
        rst_n = 1'b1;
        repeat (50) step();
        @(negedge clk);
        chk("lit_no_resume", 0, 64'(busy1 | done1), 64'h0);
        step();

        // randomised start/abort/reset traffic
        for (int n = 0; n < 1500; n++) begin
            if (!m_run[0] && !m_run[1] && ($urandom % 8) == 0) begin
                mode = int'($urandom % 3);
                tbl[$urandom % NV] = {8'($urandom), 32'($urandom)};
            end
            start = (($urandom % 25) == 0);
            abort = (($urandom % 60) == 0);
            rst_n = (($urandom % 200) != 0);
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b1;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
